// File: rtl/vrf_bank_arbiter_pkg.sv
// Shared types for the per-lane VRF bank arbiter: payload struct, arbitration classes
// and the lane datapath widths.
package vrf_bank_arbiter_pkg;

   localparam int unsigned ELEN       = 64;
   localparam int unsigned VAddrWidth = 10;
   localparam int unsigned StatsWidth = 32;

   typedef logic [VAddrWidth-1:0] lane_vaddr_t;
   typedef logic [ELEN-1:0]       elen_t;
   typedef logic [ELEN/8-1:0]     strb_t;

   typedef enum logic [2:0] {
      AluA, AluB, AluC, MulFPUA, MulFPUB, MulFPUC, StA, SlideAddrGenA
   } opqueue_e;

   typedef enum logic [1:0] {
      ArbLow, ArbHigh, ArbStarved
   } vrf_arb_class_e;

   typedef struct packed {
      lane_vaddr_t addr;
      logic        wen;
      elen_t       wdata;
      strb_t       be;
      opqueue_e    tgt_opqueue;
   } vrf_bank_req_t;

endpackage

// File: rtl/vrf_bank_arb_slice.sv
// One bank of the VRF arbiter: class select, round-robin pick, winner mux and the
// conflict counter (present only when VRF_ARB_STATS_EN is defined).
module vrf_bank_arb_slice
   import vrf_bank_arbiter_pkg::*;
#(
   parameter int unsigned NrReq     = 8,
   parameter type         payload_t = vrf_bank_req_t
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NrReq-1:0]      cand_i,
   input  logic [NrReq-1:0]      prio_i,
   input  logic [NrReq-1:0]      starved_i,
   input  payload_t              payload_i [NrReq],
   input  logic                  clear_stats_i,
   output logic [NrReq-1:0]      gnt_o,
   output logic                  req_o,
   output payload_t              payload_o,
   output logic [StatsWidth-1:0] conflict_cnt_o
);

   localparam int unsigned     IdxW    = $clog2(NrReq);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NrReq - 1);

   logic [IdxW-1:0]  rr_q;
   logic [NrReq-1:0] starved_m, high_m, low_m, class_m;
   vrf_arb_class_e   class_sel;
   logic             found;
   logic [IdxW-1:0]  winner;

   always_comb begin
      starved_m = cand_i & starved_i;
      high_m    = cand_i & prio_i & ~starved_i;
      low_m     = cand_i & ~prio_i & ~starved_i;
      if (|starved_m)   class_sel = ArbStarved;
      else if (|high_m) class_sel = ArbHigh;
      else              class_sel = ArbLow;
      case (class_sel)
         ArbStarved: class_m = starved_m;
         ArbHigh:    class_m = high_m;
         default:    class_m = low_m;
      endcase
   end

   // First set bit of the selected class at or after rr_q, wrapping modulo NrReq.
   always_comb begin
      int unsigned idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned k = 0; k < NrReq; k++) begin
         idx = 32'(rr_q) + k;
         if (idx >= NrReq) idx = idx - NrReq;
         if (!found && class_m[idx[IdxW-1:0]]) begin
            found  = 1'b1;
            winner = idx[IdxW-1:0];
         end
      end
   end

   always_comb begin
      gnt_o = '0;
      if (found) gnt_o[winner] = 1'b1;
   end

   assign req_o     = found;
   assign payload_o = found ? payload_i[winner] : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= '0;
      end else if (found) begin
         rr_q <= (winner == LastIdx) ? '0 : winner + IdxW'(1);
      end
   end

`ifdef VRF_ARB_STATS_EN
   logic                  conflict;
   logic [StatsWidth-1:0] cnt_q;

   // Two or more bits set: clearing the lowest set bit leaves something behind.
   assign conflict = (cand_i & (cand_i - NrReq'(1))) != '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear_stats_i) begin
         cnt_q <= '0;
      end else if (conflict && (cnt_q != '1)) begin
         cnt_q <= cnt_q + StatsWidth'(1);
      end
   end

   assign conflict_cnt_o = cnt_q;
`else
   logic unused_clear_stats;
   assign unused_clear_stats = clear_stats_i;
   assign conflict_cnt_o     = '0;
`endif

endmodule

// File: rtl/vrf_bank_arbiter.sv
// Per-lane arbiter sharing NrBanks single-port VRF banks among NrReq requesters.
// Define VRF_ARB_STATS_EN to enable the per-bank conflict counters.
module vrf_bank_arbiter
   import vrf_bank_arbiter_pkg::*;
#(
   parameter int unsigned NrBanks = 8,
   parameter int unsigned NrReq   = 8,
   parameter int unsigned MaxWait = 15,
   parameter type         vaddr_t = lane_vaddr_t
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NrReq-1:0]      req_i,
   input  logic [NrReq-1:0]      prio_i,
   input  vaddr_t                addr_i [NrReq],
   input  logic [NrReq-1:0]      wen_i,
   input  elen_t                 wdata_i [NrReq],
   input  strb_t                 be_i [NrReq],
   input  opqueue_e              tgt_opqueue_i [NrReq],
   output logic [NrReq-1:0]      gnt_o,
   output logic [NrBanks-1:0]    vrf_req_o,
   output vaddr_t                vrf_addr_o [NrBanks],
   output logic [NrBanks-1:0]    vrf_wen_o,
   output elen_t                 vrf_wdata_o [NrBanks],
   output strb_t                 vrf_be_o [NrBanks],
   output opqueue_e              vrf_tgt_opqueue_o [NrBanks],
   output logic [StatsWidth-1:0] conflict_cnt_o [NrBanks],
   input  logic                  clear_stats_i
);

   localparam int unsigned      BankW   = $clog2(NrBanks);
   localparam int unsigned      WaitW   = $clog2(MaxWait + 1);
   localparam logic [WaitW-1:0] WaitMax = WaitW'(MaxWait);

   typedef struct packed {
      vaddr_t   addr;
      logic     wen;
      elen_t    wdata;
      strb_t    be;
      opqueue_e tgt_opqueue;
   } payload_t;

   // Requests are masked while reset is asserted so grants drop immediately.
   logic [NrReq-1:0] req_act;
   logic [NrReq-1:0] starved;
   payload_t         req_payload [NrReq];
   logic [NrReq-1:0] gnt_acc [NrBanks+1];

   assign req_act = req_i & {NrReq{rst_ni}};

   for (genvar gi = 0; gi < NrReq; gi++) begin : g_req
      logic [WaitW-1:0] wait_q, wait_d;

      assign req_payload[gi] = '{
         addr:        vaddr_t'(addr_i[gi] >> BankW),
         wen:         wen_i[gi],
         wdata:       wdata_i[gi],
         be:          be_i[gi],
         tgt_opqueue: tgt_opqueue_i[gi]
      };
      assign starved[gi] = (wait_q == WaitMax);

      always_comb begin
         wait_d = wait_q;
         if (gnt_o[gi] || !req_i[gi]) wait_d = '0;
         else if (wait_q != WaitMax)  wait_d = wait_q + WaitW'(1);
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) wait_q <= '0;
         else         wait_q <= wait_d;
      end
   end

   assign gnt_acc[0] = '0;

   for (genvar gi = 0; gi < NrBanks; gi++) begin : g_bank
      logic [NrReq-1:0] cand;
      logic [NrReq-1:0] bank_gnt;
      payload_t         bank_payload;

      for (genvar gj = 0; gj < NrReq; gj++) begin : g_cand
         assign cand[gj] = req_act[gj] && (addr_i[gj][BankW-1:0] == BankW'(gi));
      end

      vrf_bank_arb_slice #(
         .NrReq     (NrReq),
         .payload_t (payload_t)
      ) i_slice (
         .clk_i          (clk_i),
         .rst_ni         (rst_ni),
         .cand_i         (cand),
         .prio_i         (prio_i),
         .starved_i      (starved),
         .payload_i      (req_payload),
         .clear_stats_i  (clear_stats_i),
         .gnt_o          (bank_gnt),
         .req_o          (vrf_req_o[gi]),
         .payload_o      (bank_payload),
         .conflict_cnt_o (conflict_cnt_o[gi])
      );

      assign gnt_acc[gi+1]         = gnt_acc[gi] | bank_gnt;
      assign vrf_addr_o[gi]        = bank_payload.addr;
      assign vrf_wen_o[gi]         = bank_payload.wen;
      assign vrf_wdata_o[gi]       = bank_payload.wdata;
      assign vrf_be_o[gi]          = bank_payload.be;
      assign vrf_tgt_opqueue_o[gi] = bank_payload.tgt_opqueue;
   end

   assign gnt_o = gnt_acc[NrBanks];

endmodule

// File: tb/tb_vrf_bank_arbiter.sv
// Scoreboard bench for vrf_bank_arbiter: directed stimulus pushes hand-computed grant
// vectors, a negedge monitor pops and compares whenever the DUT grants.
module tb_vrf_bank_arbiter;
   import vrf_bank_arbiter_pkg::*;

   localparam int NB = 8;
   localparam int NR = 8;

`ifdef VRF_ARB_STATS_EN
   localparam bit StatsOn = 1'b1;
`else
   localparam bit StatsOn = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [NR-1:0]     req_i, prio_i, wen_i;
   lane_vaddr_t       addr_i [NR];
   elen_t             wdata_i [NR];
   strb_t             be_i [NR];
   opqueue_e          tgt_opqueue_i [NR];
   logic [NR-1:0]     gnt_o;
   logic [NB-1:0]     vrf_req_o, vrf_wen_o;
   lane_vaddr_t       vrf_addr_o [NB];
   elen_t             vrf_wdata_o [NB];
   strb_t             vrf_be_o [NB];
   opqueue_e          vrf_tgt_opqueue_o [NB];
   logic [31:0]       conflict_cnt_o [NB];
   logic              clear_stats_i;

   always #5 clk_i = ~clk_i;

   vrf_bank_arbiter #(.NrBanks(NB), .NrReq(NR), .MaxWait(15)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .req_i             (req_i),
      .prio_i            (prio_i),
      .addr_i            (addr_i),
      .wen_i             (wen_i),
      .wdata_i           (wdata_i),
      .be_i              (be_i),
      .tgt_opqueue_i     (tgt_opqueue_i),
      .gnt_o             (gnt_o),
      .vrf_req_o         (vrf_req_o),
      .vrf_addr_o        (vrf_addr_o),
      .vrf_wen_o         (vrf_wen_o),
      .vrf_wdata_o       (vrf_wdata_o),
      .vrf_be_o          (vrf_be_o),
      .vrf_tgt_opqueue_o (vrf_tgt_opqueue_o),
      .conflict_cnt_o    (conflict_cnt_o),
      .clear_stats_i     (clear_stats_i)
   );

   typedef struct packed {
      logic [7:0]        gnt;
      logic [7:0]        breq;
      logic [7:0][9:0]   addr;
      logic [7:0]        wen;
      logic [7:0][63:0]  wdata;
      logic [7:0][7:0]   be;
      logic [7:0][2:0]   tgt;
   } exp_t;

   exp_t  exp_q [$];
   string tag_q [$];
   int    n_cmp = 0;
   int    n_err = 0;

   function automatic exp_t build_exp(input logic [7:0] g);
      exp_t e;
      logic [2:0] b;
      e = '0;
      for (int i = 0; i < NR; i++) begin
         if (g[i]) begin
            b            = addr_i[i][2:0];
            e.gnt[i]     = 1'b1;
            e.breq[b]    = 1'b1;
            e.addr[b]    = addr_i[i] >> 3;
            e.wen[b]     = wen_i[i];
            e.wdata[b]   = wdata_i[i];
            e.be[b]      = be_i[i];
            e.tgt[b]     = tgt_opqueue_i[i];
         end
      end
      return e;
   endfunction

   // Monitor: a grant is a transaction; each one must match the oldest expectation.
   always @(negedge clk_i) begin
      if ((|gnt_o) || (|vrf_req_o)) begin
         exp_t  a, e;
         string t;
         a = '0;
         a.gnt  = gnt_o;
         a.breq = vrf_req_o;
         a.wen  = vrf_wen_o;
         for (int b = 0; b < NB; b++) begin
            a.addr[b]  = vrf_addr_o[b];
            a.wdata[b] = vrf_wdata_o[b];
            a.be[b]    = vrf_be_o[b];
            a.tgt[b]   = vrf_tgt_opqueue_o[b];
         end
         if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_grant: got gnt=%b vrf_req=%b, required no grant", a.gnt, a.breq);
         end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_cmp++;
            if ({a.gnt, a.breq} !== {e.gnt, e.breq}) begin
               n_err++;
               $display("FAIL %s_gnt: got gnt=%b vrf_req=%b, required gnt=%b vrf_req=%b",
                        t, a.gnt, a.breq, e.gnt, e.breq);
            end
            n_cmp++;
            if (a !== e) begin
               n_err++;
               for (int b = 0; b < NB; b++) begin
                  if ({a.addr[b], a.wen[b], a.wdata[b], a.be[b], a.tgt[b]} !==
                      {e.addr[b], e.wen[b], e.wdata[b], e.be[b], e.tgt[b]})
                     $display("FAIL %s_payload bank%0d: got addr=%h wen=%b wdata=%h be=%h tgt=%0d, required addr=%h wen=%b wdata=%h be=%h tgt=%0d",
                              t, b, a.addr[b], a.wen[b], a.wdata[b], a.be[b], a.tgt[b],
                              e.addr[b], e.wen[b], e.wdata[b], e.be[b], e.tgt[b]);
               end
            end
            $display("[%0t] %s gnt=%b vrf_req=%b", $time, t, a.gnt, a.breq);
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // One clock: register the expected grant vector for this cycle, then advance.
   task automatic step(input logic [7:0] g, input string tag);
      if (g != '0) begin
         exp_q.push_back(build_exp(g));
         tag_q.push_back(tag);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] bank, input logic [6:0] row,
                          input logic prio, input logic wen);
      addr_i[i]        = {row, bank};
      wdata_i[i]       = 64'hC0DE_0000_0000_0000 | (64'(row) << 8) | 64'(i);
      be_i[i]          = 8'h01 << i;
      tgt_opqueue_i[i] = opqueue_e'(i[2:0]);
      wen_i[i]         = wen;
      prio_i[i]        = prio;
      req_i[i]         = 1'b1;
   endtask

   task automatic idle();
      req_i  = '0;
      prio_i = '0;
      wen_i  = '0;
      step(8'h00, "idle");
   endtask

   initial begin
      rst_ni        = 1'b0;
      clear_stats_i = 1'b0;
      req_i         = '0;
      prio_i        = '0;
      wen_i         = '0;
      for (int i = 0; i < NR; i++) begin
         addr_i[i] = '0; wdata_i[i] = '0; be_i[i] = '0; tgt_opqueue_i[i] = AluA;
      end
      repeat (2) @(posedge clk_i);
      #1;
      check("reset_gnt", 64'(gnt_o), 64'h0);
      check("reset_vrf_req", 64'(vrf_req_o), 64'h0);
      for (int b = 0; b < NB; b++) check($sformatf("reset_cnt%0d", b), 64'(conflict_cnt_o[b]), 64'h0);
      rst_ni = 1'b1;
      step(8'h00, "idle");

      // Two low-priority requesters on bank 2 alternate by round robin.
      set_req(0, 3'd2, 7'h05, 1'b0, 1'b0);
      set_req(3, 3'd2, 7'h11, 1'b0, 1'b1);
      step(8'h01, "t1_c1"); step(8'h08, "t1_c2");
      step(8'h01, "t1_c3"); step(8'h08, "t1_c4");
      idle();

      // High-priority req 1 hogs bank 0 until low req 5 is starved in cycle 16.
      set_req(1, 3'd0, 7'h01, 1'b1, 1'b0);
      set_req(5, 3'd0, 7'h02, 1'b0, 1'b1);
      for (int k = 1; k <= 17; k++) step((k == 16) ? 8'h20 : 8'h02, $sformatf("t2_c%0d", k));
      idle();

      // All requesters to distinct banks are granted together.
      for (int i = 0; i < NR; i++) set_req(i, 3'(7 - i), 7'(i + 16), 1'b0, i[0]);
      prio_i = 8'hA5;
      step(8'hFF, "t3_all");
      idle();

      // Req 2 waits 5 cycles, aborts, re-asserts and must wait a full MaxWait again.
      set_req(2, 3'd3, 7'h03, 1'b0, 1'b0);
      set_req(6, 3'd3, 7'h06, 1'b1, 1'b1);
      for (int k = 1; k <= 5; k++) step(8'h40, $sformatf("t4_wait%0d", k));
      req_i[2] = 1'b0;
      for (int k = 1; k <= 2; k++) step(8'h40, $sformatf("t4_gap%0d", k));
      req_i[2] = 1'b1;
      for (int k = 1; k <= 16; k++) step((k == 16) ? 8'h04 : 8'h40, $sformatf("t4_re%0d", k));
      idle();

      // Reset mid-arbitration on bank 4 clears rr and waits; order restarts at req 0.
      set_req(0, 3'd4, 7'h20, 1'b0, 1'b1);
      set_req(1, 3'd4, 7'h21, 1'b0, 1'b0);
      set_req(2, 3'd4, 7'h22, 1'b0, 1'b1);
      step(8'h01, "t5_pre1"); step(8'h02, "t5_pre2");
      rst_ni = 1'b0;
      #1;
      check("t5_rst_gnt", 64'(gnt_o), 64'h0);
      check("t5_rst_vrf_req", 64'(vrf_req_o), 64'h0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      step(8'h01, "t5_post1"); step(8'h02, "t5_post2"); step(8'h04, "t5_post3");
      idle();

      // Ten two-way conflicts on bank 1, then a clear during an eleventh conflict.
      set_req(0, 3'd1, 7'h30, 1'b0, 1'b0);
      set_req(1, 3'd1, 7'h31, 1'b0, 1'b1);
      for (int k = 1; k <= 10; k++) step(k[0] ? 8'h01 : 8'h02, $sformatf("t6_c%0d", k));
      check("t6_cnt1_before_clear", 64'(conflict_cnt_o[1]), StatsOn ? 64'd10 : 64'd0);
      check("t6_cnt4_before_clear", 64'(conflict_cnt_o[4]), StatsOn ? 64'd3 : 64'd0);
      clear_stats_i = 1'b1;
      step(8'h01, "t6_clear");
      clear_stats_i = 1'b0;
      check("t6_cnt1_after_clear", 64'(conflict_cnt_o[1]), 64'd0);
      check("t6_cnt4_after_clear", 64'(conflict_cnt_o[4]), 64'd0);
      idle();
      idle();

      check("pending_expectations", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
